// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the CPU memory controller: FSM states, grant
// identifiers, access size codes, IO window base and a size decode helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_LSU = 1'b1
  } grant_t;

  localparam logic [1:0]  SIZE_B  = 2'b00;
  localparam logic [1:0]  SIZE_H  = 2'b01;
  localparam logic [1:0]  SIZE_W  = 2'b10;

  // Addresses from here up are memory-mapped IO; reads there have side effects.
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  // Number of byte beats for an LSU size code; 11 is treated as a word.
  function automatic logic [2:0] size_to_beats(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// CPU-side memory controller. Arbitrates the byte-wide memory bus between
// instruction fetch and the LSU, splits accesses into little-endian byte
// beats and reassembles read data.
//
// Handshake: a requester raises *_req with stable inputs and holds it until
// its *_done pulses for exactly one cycle (data valid that cycle only). The
// FIN state ignores requests, so a req still high during done is not
// re-granted; the next grant happens at the earliest one cycle later.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_in,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  lsu_req,
  input  logic                  lsu_wr,
  input  logic [1:0]            lsu_size,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [31:0]           lsu_wdata,
  output logic                  lsu_done,
  output logic [31:0]           lsu_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  output state_t                dbg_state
);

  state_t                state_q, state_d;
  grant_t                gnt_q, gnt_d;
  grant_t                last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            beats_q, beats_d;
  logic                  wr_q, wr_d;
  logic [31:0]           wdata_q, wdata_d;
  // iss: next beat to put on mem_a; cap: next byte to capture from mem_din.
  logic [2:0]            iss_q, iss_d;
  logic [2:0]            cap_q, cap_d;
  // va: mem_a carries a read beat this cycle; vd: mem_din carries byte cap.
  logic                  va_q, va_d;
  logic                  vd_q, vd_d;
  logic [31:0]           data_q, data_d;

  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  if_done_q, if_done_d;
  logic                  lsu_done_q, lsu_done_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           lsu_rdata_q, lsu_rdata_d;

  logic                  want_if;
  logic                  pick_lsu;
  logic [31:0]           data_nxt;

  // State, request latch and registered outputs; reset wins over everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_IF;
      last_q      <= GNT_IF;
      addr_q      <= '0;
      beats_q     <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      iss_q       <= '0;
      cap_q       <= '0;
      va_q        <= 1'b0;
      vd_q        <= 1'b0;
      data_q      <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      lsu_done_q  <= 1'b0;
      if_data_q   <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      iss_q       <= iss_d;
      cap_q       <= cap_d;
      va_q        <= va_d;
      vd_q        <= vd_d;
      data_q      <= data_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      lsu_done_q  <= lsu_done_d;
      if_data_q   <= if_data_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  // Arbitration, beat sequencing, byte capture and next-cycle bus values.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    iss_d       = iss_q;
    cap_d       = cap_q;
    va_d        = va_q;
    vd_d        = vd_q;
    data_d      = data_q;
    // The bus idles at address 0 so an IO address is only present for a real beat.
    mem_a_d     = '0;
    mem_dout_d  = '0;
    mem_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    lsu_done_d  = 1'b0;
    if_data_d   = if_data_q;
    lsu_rdata_d = lsu_rdata_q;
    data_nxt    = data_q;
    // A flush in the sampling cycle cancels the fetch request.
    want_if     = if_req & ~clear_in;
    pick_lsu    = lsu_req & (~want_if | (last_q == GNT_IF));

    case (state_q)
      ST_IDLE: begin
        if (rdy_in && (want_if || lsu_req)) begin
          gnt_d      = pick_lsu ? GNT_LSU : GNT_IF;
          addr_d     = pick_lsu ? lsu_addr : if_addr;
          beats_d    = pick_lsu ? size_to_beats(lsu_size) : 3'd4;
          wr_d       = pick_lsu & lsu_wr;
          wdata_d    = lsu_wdata;
          iss_d      = 3'd1;
          cap_d      = 3'd0;
          data_d     = '0;
          va_d       = ~(pick_lsu & lsu_wr);
          vd_d       = 1'b0;
          mem_a_d    = pick_lsu ? lsu_addr : if_addr;
          mem_wr_d   = pick_lsu & lsu_wr;
          mem_dout_d = (pick_lsu & lsu_wr) ? lsu_wdata[7:0] : 8'h00;
          state_d    = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (clear_in && (gnt_q == GNT_IF)) begin
          // Flushed fetch: drop whatever is in flight.
          state_d = ST_IDLE;
          va_d    = 1'b0;
          vd_d    = 1'b0;
        end else if (!rdy_in) begin
          // Bus lent to debug: in-flight read beats are lost and re-issued
          // from the capture point; issued write beats count as done.
          va_d = 1'b0;
          vd_d = 1'b0;
          if (!wr_q) begin
            iss_d = cap_q;
          end
        end else if (wr_q) begin
          if (iss_q == beats_q) begin
            state_d    = ST_FIN;
            lsu_done_d = 1'b1;
          end else begin
            mem_a_d    = addr_q + ADDR_WIDTH'(iss_q);
            mem_dout_d = wdata_q[{iss_q[1:0], 3'b000} +: 8];
            mem_wr_d   = 1'b1;
            iss_d      = iss_q + 3'd1;
          end
        end else begin
          if (vd_q) begin
            data_nxt[{cap_q[1:0], 3'b000} +: 8] = mem_din;
            cap_d = cap_q + 3'd1;
          end
          data_d = data_nxt;
          vd_d   = va_q;
          if (iss_q != beats_q) begin
            mem_a_d = addr_q + ADDR_WIDTH'(iss_q);
            iss_d   = iss_q + 3'd1;
            va_d    = 1'b1;
          end else begin
            va_d = 1'b0;
          end
          if (vd_q && ((cap_q + 3'd1) == beats_q)) begin
            state_d = ST_FIN;
            va_d    = 1'b0;
            vd_d    = 1'b0;
            if (gnt_q == GNT_LSU) begin
              lsu_done_d  = 1'b1;
              lsu_rdata_d = data_nxt;
            end else begin
              if_done_d = 1'b1;
              if_data_d = data_nxt;
            end
          end
        end
      end

      ST_FIN: begin
        if (clear_in && (gnt_q == GNT_IF)) begin
          state_d = ST_IDLE;
          last_d  = gnt_q;
        end else if (rdy_in) begin
          state_d = ST_IDLE;
          last_d  = gnt_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign lsu_done  = lsu_done_q;
  assign lsu_rdata = lsu_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a byte-wide memory model and an IO
// location that counts read cycles.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsu_req;
  logic        lsu_wr;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  state_t      dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          io_cnt  = 0;
  logic        ram_init;
  logic [7:0]  ram [0:1023];

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .clear_in  (clear_in),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_data   (if_data),
    .lsu_req   (lsu_req),
    .lsu_wr    (lsu_wr),
    .lsu_size  (lsu_size),
    .lsu_addr  (lsu_addr),
    .lsu_wdata (lsu_wdata),
    .lsu_done  (lsu_done),
    .lsu_rdata (lsu_rdata),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_a     (mem_a),
    .mem_wr    (mem_wr),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk_in = ~clk_in;

  // Memory model: read data one cycle after the address; IO reads counted.
  always @(posedge clk_in) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
      ram[10'h100] = 8'h11; ram[10'h101] = 8'h22;
      ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
      ram[10'h120] = 8'h34; ram[10'h121] = 8'hF2; ram[10'h122] = 8'h55;
      ram[10'h211] = 8'h99;
    end else begin
      mem_din <= (mem_a == IO_BASE) ? 8'hA7 : ram[mem_a[9:0]];
      if (mem_a == IO_BASE && !mem_wr) io_cnt = io_cnt + 1;
      if (mem_wr) ram[mem_a[9:0]] = mem_dout;
    end
  end

  // Advance one cycle and land just after the active edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    clear_in  = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    lsu_req   = 1'b0;
    lsu_wr    = 1'b0;
    lsu_size  = SIZE_B;
    lsu_addr  = '0;
    lsu_wdata = '0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick();
    tick();
    n_tests++;
    if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_bus: mem_a=%h mem_wr=%b mem_dout=%h, want 0/0/0", mem_a, mem_wr, mem_dout);
    end
    n_tests++;
    if (if_done !== 1'b0 || lsu_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: if_done=%b lsu_done=%b, want 0/0", if_done, lsu_done);
    end
    n_tests++;
    if (if_data !== 32'h0 || lsu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: if_data=%h lsu_rdata=%h, want 0/0", if_data, lsu_rdata);
    end
    n_tests++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d, want %0d", dbg_state, ST_IDLE);
    end
    rst_in = 1'b0;
  endtask

  task automatic test_if_read();
    logic [31:0] exp_a;
    if_addr = 32'h100;
    if_req  = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      exp_a = (cyc <= 4) ? 32'h100 + 32'(cyc - 1) : 32'h0;
      n_tests++;
      if (mem_a !== exp_a || mem_wr !== 1'b0) begin
        n_fail++;
        $display("FAIL if_read_bus cyc=%0d: mem_a=%h mem_wr=%b, want %h/0", cyc, mem_a, mem_wr, exp_a);
      end
      n_tests++;
      if (if_done !== (cyc == 6)) begin
        n_fail++;
        $display("FAIL if_read_done cyc=%0d: if_done=%b, want %b", cyc, if_done, (cyc == 6));
      end
      if (cyc == 6) begin
        n_tests++;
        if (if_data !== 32'h44332211) begin
          n_fail++;
          $display("FAIL if_read_data: if_data=%h, want 44332211", if_data);
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_store_word();
    logic [31:0] wd;
    logic [31:0] exp_a;
    logic [7:0]  exp_d;
    logic        exp_wr;
    wd        = 32'hDEADBEEF;
    lsu_addr  = 32'h200;
    lsu_wdata = wd;
    lsu_size  = SIZE_W;
    lsu_wr    = 1'b1;
    lsu_req   = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      exp_wr = (cyc <= 4);
      exp_a  = (cyc <= 4) ? 32'h200 + 32'(cyc - 1) : 32'h0;
      exp_d  = (cyc <= 4) ? wd[8*(cyc-1) +: 8] : 8'h00;
      n_tests++;
      if (mem_wr !== exp_wr || mem_a !== exp_a || mem_dout !== exp_d) begin
        n_fail++;
        $display("FAIL store_word_bus cyc=%0d: wr=%b a=%h d=%h, want %b/%h/%h",
                 cyc, mem_wr, mem_a, mem_dout, exp_wr, exp_a, exp_d);
      end
      n_tests++;
      if (lsu_done !== (cyc == 5)) begin
        n_fail++;
        $display("FAIL store_word_done cyc=%0d: lsu_done=%b, want %b", cyc, lsu_done, (cyc == 5));
      end
      if (cyc == 5) idle_inputs();
    end
    n_tests++;
    if ({ram[10'h203], ram[10'h202], ram[10'h201], ram[10'h200]} !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL store_word_mem: ram=%h, want deadbeef",
               {ram[10'h203], ram[10'h202], ram[10'h201], ram[10'h200]});
    end
  endtask

  task automatic test_store_byte();
    lsu_addr  = 32'h210;
    lsu_wdata = 32'h12345677;
    lsu_size  = SIZE_B;
    lsu_wr    = 1'b1;
    lsu_req   = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tick();
      n_tests++;
      if (mem_wr !== (cyc == 1) || mem_a !== ((cyc == 1) ? 32'h210 : 32'h0)) begin
        n_fail++;
        $display("FAIL store_byte_bus cyc=%0d: wr=%b a=%h, want %b", cyc, mem_wr, mem_a, (cyc == 1));
      end
      n_tests++;
      if (lsu_done !== (cyc == 2)) begin
        n_fail++;
        $display("FAIL store_byte_done cyc=%0d: lsu_done=%b, want %b", cyc, lsu_done, (cyc == 2));
      end
      if (cyc == 2) idle_inputs();
    end
    n_tests++;
    if (ram[10'h210] !== 8'h77 || ram[10'h211] !== 8'h99) begin
      n_fail++;
      $display("FAIL store_byte_mem: ram210=%h ram211=%h, want 77/99", ram[10'h210], ram[10'h211]);
    end
  endtask

  task automatic test_io_load();
    int base;
    base     = io_cnt;
    lsu_addr = IO_BASE;
    lsu_size = SIZE_B;
    lsu_wr   = 1'b0;
    lsu_req  = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      if (cyc == 1) begin
        n_tests++;
        if (mem_a !== IO_BASE) begin
          n_fail++;
          $display("FAIL io_load_addr: mem_a=%h, want %h", mem_a, IO_BASE);
        end
      end
      n_tests++;
      if (lsu_done !== (cyc == 3)) begin
        n_fail++;
        $display("FAIL io_load_done cyc=%0d: lsu_done=%b, want %b", cyc, lsu_done, (cyc == 3));
      end
      if (cyc == 3) begin
        n_tests++;
        if (lsu_rdata !== 32'h000000A7) begin
          n_fail++;
          $display("FAIL io_load_data: lsu_rdata=%h, want 000000a7", lsu_rdata);
        end
        idle_inputs();
      end
    end
    n_tests++;
    if (io_cnt - base !== 1) begin
      n_fail++;
      $display("FAIL io_load_beats: io reads=%0d, want 1", io_cnt - base);
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    if_addr  = 32'h100;
    if_req   = 1'b1;
    lsu_addr = 32'h200;
    lsu_size = SIZE_W;
    lsu_wr   = 1'b0;
    lsu_req  = 1'b1;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      tick();
      n_tests++;
      if (lsu_done !== (cyc == 6 || cyc == 17)) begin
        n_fail++;
        $display("FAIL arb_lsu_done cyc=%0d: lsu_done=%b", cyc, lsu_done);
      end
      n_tests++;
      if (if_done !== (cyc == 13)) begin
        n_fail++;
        $display("FAIL arb_if_done cyc=%0d: if_done=%b", cyc, if_done);
      end
      if (cyc == 1 || cyc == 8 || cyc == 15) begin
        n_tests++;
        if (mem_a !== ((cyc == 1) ? 32'h200 : (cyc == 8) ? 32'h100 : 32'h101)) begin
          n_fail++;
          $display("FAIL arb_grant cyc=%0d: mem_a=%h", cyc, mem_a);
        end
      end
      if (cyc == 6) begin
        n_tests++;
        if (lsu_rdata !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL arb_lsu_data1: lsu_rdata=%h, want deadbeef", lsu_rdata);
        end
        lsu_addr = 32'h101;
        lsu_size = SIZE_B;
      end
      if (cyc == 13) begin
        n_tests++;
        if (if_data !== 32'h44332211) begin
          n_fail++;
          $display("FAIL arb_if_data: if_data=%h, want 44332211", if_data);
        end
        if_req = 1'b0;
      end
      if (cyc == 17) begin
        n_tests++;
        if (lsu_rdata !== 32'h00000022) begin
          n_fail++;
          $display("FAIL arb_lsu_data2: lsu_rdata=%h, want 00000022", lsu_rdata);
        end
        idle_inputs();
      end
    end
  endtask

  task automatic test_clear();
    if_addr = 32'h100;
    if_req  = 1'b1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      tick();
      n_tests++;
      if (if_done !== (cyc == 16)) begin
        n_fail++;
        $display("FAIL clear_if_done cyc=%0d: if_done=%b", cyc, if_done);
      end
      n_tests++;
      if (lsu_done !== (cyc == 7)) begin
        n_fail++;
        $display("FAIL clear_lsu_done cyc=%0d: lsu_done=%b", cyc, lsu_done);
      end
      case (cyc)
        2: begin
          lsu_addr = 32'h103;
          lsu_size = SIZE_B;
          lsu_wr   = 1'b0;
          lsu_req  = 1'b1;
        end
        3: begin
          n_tests++;
          if (mem_a !== 32'h102) begin
            n_fail++;
            $display("FAIL clear_byte2: mem_a=%h, want 00000102", mem_a);
          end
          clear_in = 1'b1;
        end
        4: begin
          n_tests++;
          if (dbg_state !== ST_IDLE || mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_idle: state=%0d mem_wr=%b, want %0d/0", dbg_state, mem_wr, ST_IDLE);
          end
          clear_in = 1'b0;
          if_req   = 1'b0;
        end
        5: begin
          n_tests++;
          if (mem_a !== 32'h103) begin
            n_fail++;
            $display("FAIL clear_lsu_grant: mem_a=%h, want 00000103", mem_a);
          end
        end
        7: begin
          n_tests++;
          if (lsu_rdata !== 32'h00000044) begin
            n_fail++;
            $display("FAIL clear_lsu_data: lsu_rdata=%h, want 00000044", lsu_rdata);
          end
          lsu_req = 1'b0;
        end
        9: begin
          if_req   = 1'b1;
          clear_in = 1'b1;
        end
        10: begin
          n_tests++;
          if (dbg_state !== ST_IDLE || mem_a !== 32'h0) begin
            n_fail++;
            $display("FAIL clear_in_idle: state=%0d mem_a=%h, want %0d/0", dbg_state, mem_a, ST_IDLE);
          end
          clear_in = 1'b0;
        end
        11: begin
          n_tests++;
          if (mem_a !== 32'h100) begin
            n_fail++;
            $display("FAIL clear_if_regrant: mem_a=%h, want 00000100", mem_a);
          end
        end
        16: begin
          n_tests++;
          if (if_data !== 32'h44332211) begin
            n_fail++;
            $display("FAIL clear_if_data: if_data=%h, want 44332211", if_data);
          end
          if_req = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_rdy_stall();
    lsu_addr = 32'h120;
    lsu_size = SIZE_H;
    lsu_wr   = 1'b0;
    lsu_req  = 1'b1;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      tick();
      n_tests++;
      if (mem_wr !== 1'b0 || mem_a === 32'h122) begin
        n_fail++;
        $display("FAIL stall_bus cyc=%0d: mem_wr=%b mem_a=%h", cyc, mem_wr, mem_a);
      end
      n_tests++;
      if (lsu_done !== (cyc == 9)) begin
        n_fail++;
        $display("FAIL stall_done cyc=%0d: lsu_done=%b, want %b", cyc, lsu_done, (cyc == 9));
      end
      if (cyc == 1 || cyc == 6 || cyc == 7) begin
        n_tests++;
        if (mem_a !== ((cyc == 7) ? 32'h121 : 32'h120)) begin
          n_fail++;
          $display("FAIL stall_issue cyc=%0d: mem_a=%h", cyc, mem_a);
        end
      end
      if (cyc == 2) rdy_in = 1'b0;
      if (cyc == 5) rdy_in = 1'b1;
      if (cyc == 9) begin
        n_tests++;
        if (lsu_rdata !== 32'h0000F234) begin
          n_fail++;
          $display("FAIL stall_data: lsu_rdata=%h, want 0000f234", lsu_rdata);
        end
        idle_inputs();
      end
    end
  endtask

  task automatic test_reset_mid();
    if_addr = 32'h100;
    if_req  = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      n_tests++;
      if (if_done !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_done cyc=%0d: if_done=%b, want 0", cyc, if_done);
      end
      if (cyc == 2) rst_in = 1'b1;
      if (cyc == 3) begin
        n_tests++;
        if (dbg_state !== ST_IDLE || mem_a !== 32'h0 || mem_wr !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_mid_idle: state=%0d mem_a=%h mem_wr=%b", dbg_state, mem_a, mem_wr);
        end
        rst_in = 1'b0;
        if_req = 1'b0;
      end
    end
  endtask

  initial begin
    idle_inputs();
    rdy_in   = 1'b1;
    rst_in   = 1'b1;
    ram_init = 1'b1;
    tick();
    tick();
    ram_init = 1'b0;
    test_reset();
    test_if_read();
    test_store_word();
    test_store_byte();
    test_io_load();
    test_arbitration();
    test_clear();
    test_rdy_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
